// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that grants one of two requesters a 16-bit full-duplex SPI exchange
// ports: req/req_data0/req_data1 requests with one-hot gnt ack; ckp/cph SPI mode; ss_n/sck/mosi/miso bus;
//        busy while a transfer runs; rsp_valid/rsp_id/rsp_data return the received word
module spi_txn_arbiter #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  input  logic        ckp,
  input  logic        cph,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [1:0]  ss_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data
);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] tgl_q, tgl_d, k;
  logic [15:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic [1:0] gnt_q, gnt_d, ss_n_q, ss_n_d;
  logic id_q, id_d, ckp_q, ckp_d, cph_q, cph_d, last_q, last_d;
  logic busy_q, busy_d, sck_q, sck_d, mosi_q, mosi_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic tick, tog, smp, shf, win;
  assign tick = cnt_q == 8'(DIV - 1);
  assign win = &req ? ~last_q : req[1];
  // k is the index of the sck toggle happening at this edge; even = leading, odd = trailing
  assign k = state_q == SETUP ? 5'd0 : tgl_q + 5'd1;
  assign tog = tick && (state_q == SETUP || (state_q == XFER && tgl_q != 5'd31));
  assign smp = tog && (k[0] == cph_q);
  // in mode cph=1 the first leading edge only launches the clock; tx[0] is already on mosi
  assign shf = tog && (cph_q ? (!k[0] && k != 5'd0) : k[0]);
  always_ff @(posedge clk)
    state_q <= !rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |req ? SETUP : IDLE;
      SETUP:   state_d = tick ? XFER : SETUP;
      XFER:    state_d = (tick && tgl_q == 5'd31) ? HOLD : XFER;
      HOLD:    state_d = tick ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = (state_d != state_q || tick) ? 8'd0 : cnt_q + 8'd1;
    tgl_d = tog ? k : tgl_q;
    tx_d = shf ? tx_q >> 1 : tx_q;
    mosi_d = shf ? tx_q[1] : mosi_q;
    rx_d = smp ? {miso, rx_q[15:1]} : rx_q;
    sck_d = tog ? ~sck_q : sck_q;
    id_d = id_q;
    ckp_d = ckp_q;
    cph_d = cph_q;
    last_d = last_q;
    gnt_d = 2'b00;
    busy_d = busy_q;
    ss_n_d = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_id_d = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (state_q == IDLE && |req) begin
      id_d = win;
      ckp_d = ckp;
      cph_d = cph;
      tx_d = win ? req_data1 : req_data0;
      mosi_d = win ? req_data1[0] : req_data0[0];
      rx_d = 16'h0;
      tgl_d = 5'd0;
      sck_d = ckp;
      gnt_d = win ? 2'b10 : 2'b01;
      ss_n_d = win ? 2'b01 : 2'b10;
      busy_d = 1'b1;
    end
    if (state_q == HOLD && tick) begin
      ss_n_d = 2'b11;
      busy_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_id_d = id_q;
      rsp_data_d = rx_q;
      last_d = id_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      tgl_q <= 5'd0;
      tx_q <= 16'h0;
      rx_q <= 16'h0;
      id_q <= 1'b0;
      ckp_q <= 1'b0;
      cph_q <= 1'b0;
      last_q <= 1'b1;
      gnt_q <= 2'b00;
      busy_q <= 1'b0;
      ss_n_q <= 2'b11;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_data_q <= 16'h0;
    end else begin
      cnt_q <= cnt_d;
      tgl_q <= tgl_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      id_q <= id_d;
      ckp_q <= ckp_d;
      cph_q <= cph_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      ss_n_q <= ss_n_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign gnt = gnt_q;
  assign busy = busy_q;
  assign ss_n = ss_n_q;
  assign sck = sck_q;
  assign mosi = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed bench with per-cycle transaction model for DIV=2 and DIV=1 instances
module tb_spi_txn_arbiter;
  logic clk = 0, rst = 0, ckp = 0, cph = 0;
  logic [1:0] req = 0;
  logic [15:0] d0 = 0, d1 = 0, slave_w = 0;
  logic [1:0] gnt [2];
  logic [1:0] ss_n [2];
  logic busy [2], sck [2], mosi [2], rv [2], rid [2];
  logic [15:0] rd [2];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int inst, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, inst, cyc, a, e);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int D = g == 0 ? 2 : 1;
    logic mi = 0, prev_sck = 0;
    logic [1:0] prev_ss = 2'b11;
    logic [15:0] srx = 0;
    int n = 0;
    bit on = 0, act = 0, mid = 0, mckp = 0, mcph = 0, last = 1, ev = 0, eid = 0, isck = 0;
    int off = 0;
    logic [15:0] mtx = 0, mw = 0, ed = 0;
    spi_txn_arbiter #(.DIV(D)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data0(d0), .req_data1(d1), .ckp(ckp), .cph(cph),
      .gnt(gnt[g]), .busy(busy[g]), .ss_n(ss_n[g]), .sck(sck[g]), .mosi(mosi[g]), .miso(mi),
      .rsp_valid(rv[g]), .rsp_id(rid[g]), .rsp_data(rd[g])
    );
    // slave: counts sck toggles; bit j of its word stays on miso until the j-th sampling edge
    always @(negedge clk) begin
      if (ss_n[g] != 2'b11) begin
        if (prev_ss == 2'b11) begin
          n = 0;
          srx = 0;
        end else if (sck[g] != prev_sck) begin
          n++;
          if (((n - 1) & 1) == int'(cph)) srx = {mosi[g], srx[15:1]};
        end
      end
      prev_sck = sck[g];
      prev_ss = ss_n[g];
      mi = slave_w[(n / 2) > 15 ? 15 : n / 2];
    end
    // model: a transaction is a window of 34*D cycles starting at its grant cycle
    always @(posedge clk) begin
      if (!rst) begin
        on = 1; act = 0; last = 1; ev = 0; eid = 0; ed = 0; isck = 0;
      end else if (!act) begin
        ev = 0;
        if (req != 0) begin
          act = 1; off = 0;
          mid = req == 2'b11 ? !last : req[1];
          mckp = ckp; mcph = cph; mtx = mid ? d1 : d0; mw = slave_w;
        end
      end else begin
        off++;
        if (off == 34 * D) begin
          act = 0; ev = 1; eid = mid; ed = mw; last = mid; isck = mckp;
        end
      end
    end
    always @(negedge clk) if (on) begin
      int nt, bi;
      nt = (!act || off < D) ? 0 : (((off - D) / D + 1) > 32 ? 32 : (off - D) / D + 1);
      bi = mcph ? (nt == 0 ? 0 : (nt - 1) / 2) : nt / 2;
      chk("gnt", g, 16'(gnt[g]), (act && off == 0) ? (mid ? 16'd2 : 16'd1) : 16'd0);
      chk("busy", g, 16'(busy[g]), 16'(act));
      chk("ss_n", g, 16'(ss_n[g]), act ? (mid ? 16'd1 : 16'd2) : 16'd3);
      chk("sck", g, 16'(sck[g]), act ? 16'(mckp ^ nt[0]) : 16'(isck));
      if (act) chk("mosi", g, 16'(mosi[g]), bi > 15 ? 16'd0 : 16'(mtx[bi]));
      chk("rsp_valid", g, 16'(rv[g]), 16'(ev));
      chk("rsp_id", g, 16'(rid[g]), 16'(eid));
      chk("rsp_data", g, rd[g], ed);
    end
  end
  task automatic wait_g(input int inst, output int t);
    int k = 0;
    while (gnt[inst] == 2'b00 && k < 500) begin @(negedge clk); k++; end
    if (k == 500) chk("gnt_timeout", inst, 16'd1, 16'd0);
    t = cyc;
  endtask
  task automatic wait_rv(input int inst, output int t);
    int k = 0;
    while (!rv[inst] && k < 500) begin @(negedge clk); k++; end
    if (k == 500) chk("rsp_timeout", inst, 16'd1, 16'd0);
    t = cyc;
  endtask
  task automatic txn(input logic [1:0] r, input logic [15:0] a, input logic [15:0] w, input logic cp, input logic ch,
                     output logic [1:0] gv, output int tg, output int tr);
    req = r; d0 = a; d1 = a; slave_w = w; ckp = cp; cph = ch;
    wait_g(0, tg);
    gv = gnt[0];
    req = 0;
    wait_rv(0, tr);
  endtask
  initial begin
    logic [1:0] gv;
    int tg, tr, t1, t2, t3, cnt;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_gnt", 0, 16'(gnt[0]), 16'd0);
    chk("rst_ss_n", 0, 16'(ss_n[0]), 16'd3);
    chk("rst_sck", 0, 16'(sck[0]), 16'd0);
    chk("rst_busy", 0, 16'(busy[0]), 16'd0);
    chk("rst_rsp", 0, rd[0], 16'd0);
    txn(2'b01, 16'hA5C3, 16'h3C5A, 0, 0, gv, tg, tr);
    chk("basic_gnt", 0, 16'(gv), 16'd1);
    chk("basic_lat", 0, 16'(tr - tg), 16'd68);
    chk("basic_id", 0, 16'(rid[0]), 16'd0);
    chk("basic_data", 0, rd[0], 16'h3C5A);
    chk("basic_mosi", 0, g_i[0].srx, 16'hA5C3);
    chk("basic_pulses", 0, 16'(g_i[0].n), 16'd32);
    for (int m = 0; m < 4; m++) begin
      txn(2'b01, 16'h8001, 16'h8001, m[1], m[0], gv, tg, tr);
      chk("mode_idle_sck", m, 16'(sck[0]), 16'(m[1]));
      chk("mode_rx", m, rd[0], 16'h8001);
      chk("mode_tx", m, g_i[0].srx, 16'h8001);
    end
    rst = 0;
    @(negedge clk);
    rst = 1;
    req = 2'b11; ckp = 0; cph = 0; d0 = 16'h1234; d1 = 16'hBEEF; slave_w = 16'h0F0F;
    wait_g(0, t1);
    chk("rr_first", 0, 16'(gnt[0]), 16'd1);
    @(negedge clk);
    wait_g(0, t2);
    chk("rr_second", 0, 16'(gnt[0]), 16'd2);
    chk("rr_gap1", 0, 16'(t2 - t1), 16'd69);
    @(negedge clk);
    wait_g(0, t3);
    chk("rr_third", 0, 16'(gnt[0]), 16'd1);
    chk("rr_gap2", 0, 16'(t3 - t2), 16'd69);
    repeat (30) @(negedge clk);
    req = 2'b01;
    wait_g(0, tg);
    chk("drop_gnt", 0, 16'(gnt[0]), 16'd1);
    chk("drop_gap", 0, 16'(tg - t3), 16'd69);
    req = 0;
    wait_rv(0, tr);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (gnt[0] != 0) cnt++; end
    chk("no_req_gnt", 0, 16'(cnt), 16'd0);
    req = 2'b01; slave_w = 16'h5555;
    wait_g(0, tg);
    req = 0;
    repeat (20) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("abort_ss_n", 0, 16'(ss_n[0]), 16'd3);
    chk("abort_sck", 0, 16'(sck[0]), 16'd0);
    chk("abort_busy", 0, 16'(busy[0]), 16'd0);
    cnt = 0;
    repeat (80) begin @(negedge clk); if (rv[0]) cnt++; end
    chk("abort_no_rsp", 0, 16'(cnt), 16'd0);
    req = 2'b11;
    wait_g(0, tg);
    chk("abort_regrant", 0, 16'(gnt[0]), 16'd1);
    req = 0;
    wait_rv(0, tr);
    repeat (5) @(negedge clk);
    req = 2'b10; slave_w = 16'hC3A5; d1 = 16'h7E81;
    wait_g(1, t1);
    chk("div1_gnt", 1, 16'(gnt[1]), 16'd2);
    wait_rv(1, t2);
    chk("div1_lat", 1, 16'(t2 - t1), 16'd34);
    chk("div1_data", 1, rd[1], 16'hC3A5);
    @(negedge clk);
    wait_g(1, t3);
    chk("div1_b2b", 1, 16'(t3 - t2), 16'd1);
    wait_rv(1, tr);
    chk("div1_lat2", 1, 16'(tr - t3), 16'd34);
    req = 0;
    repeat (150) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: DIV, default 2, SCK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 req  input  2  level request per requester; bit i targets slave i.
REQ-005 req_data0  input  16  word to send for requester 0.
REQ-006 req_data1  input  16  word to send for requester 1.
REQ-007 ckp  input  1  SCK idle polarity, sampled at arbitration.
REQ-008 cph  input  1  SCK phase, sampled at arbitration; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 gnt  output  2  one-hot, one-cycle grant acknowledge.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 ss_n  output  2  active-low slave selects; bit i selects slave i.
REQ-012 sck  output  1  serial clock to the slaves.
REQ-013 mosi  output  1  serial data to the slaves.
REQ-014 miso  input  1  serial data from the selected slave.
REQ-015 rsp_valid  output  1  one-cycle pulse when the received word is valid.
REQ-016 rsp_id  output  1  requester index for the current response.
REQ-017 rsp_data  output  16  word received on miso.

Function
REQ-018 FSM states: IDLE, SETUP, XFER, HOLD. All outputs are registered.
REQ-019 Arbitration in IDLE only. With a single requester, grant that requester. With both requesting, grant the requester not served last (round-robin). The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-020 On the IDLE cycle where any req bit is high, the following are latched at the same edge: the winner id, its req_data word, ckp and cph. The state then moves to SETUP.
REQ-021 gnt[id] is high for exactly the first SETUP cycle, called cycle T.
REQ-022 A requester holds req until it sees gnt. Dropping req before gnt withdraws the request with no side effects. req is ignored outside IDLE.
REQ-023 SETUP lasts DIV cycles (T .. T+DIV-1):
 - ss_n[id] = 0, other ss_n bit = 1;
 - sck = latched ckp;
 - mosi = tx[0].
REQ-024 XFER lasts 32*DIV cycles (T+DIV .. T+33*DIV-1). sck toggles every DIV cycles, giving 16 full periods. The first toggle is the leading edge, at T+DIV.
REQ-025 cph=0 behaviour:
 - miso is sampled on each leading edge: rx <= {miso, rx[15:1]};
 - tx shifts right on each trailing edge, so mosi presents the next bit.
REQ-026 cph=1 behaviour:
 - tx shifts right on each leading edge, except the first;
 - miso is sampled on each trailing edge with the same shift as REQ-025.
REQ-027 Bit order is LSB first in both directions. After 16 samples, rx[0] holds the first bit received.
REQ-028 At the end of XFER, sck has returned to ckp.
REQ-029 HOLD lasts DIV cycles (T+33*DIV .. T+34*DIV-1). ss_n[id] stays 0 and sck = ckp.
REQ-030 Return to IDLE at cycle T+34*DIV. In that same cycle:
 - ss_n = 2'b11;
 - rsp_valid = 1 for exactly one cycle;
 - rsp_id = id and rsp_data = rx;
 - the last-served pointer is updated to id.
REQ-031 rsp_data and rsp_id hold their values until the next response.
REQ-032 A new arbitration may occur in the same IDLE cycle that carries rsp_valid. The next gnt then appears at T+34*DIV+1.
REQ-033 In IDLE, sck holds the last latched ckp. ckp and cph changes during a transaction are ignored.
REQ-034 An internal divide counter spans 0..DIV-1 and wraps. It is cleared on every state entry.

Reset
REQ-035 While rst=0 at a rising edge, the block forces the following at that edge:
 - state IDLE;
 - gnt=0, busy=0, ss_n=2'b11, sck=0, mosi=0;
 - rsp_valid=0, rsp_id=0, rsp_data=0;
 - last-served pointer=1;
 - tx, rx and counters cleared.
REQ-036 Reset asserted mid-transaction aborts it. ss_n goes to 11 at the next edge and no rsp_valid is produced.

Verification
REQ-037 DIV=2, ckp=0, cph=0, req=01, req_data0=16'hA5C3, slave returns 16'h3C5A LSB-first:
 - gnt=01 at T;
 - ss_n=10 from T to T+67;
 - 16 sck pulses;
 - mosi bits LSB-first of A5C3;
 - rsp_valid, rsp_id=0, rsp_data=16'h3C5A at T+68.
REQ-038 All four (ckp, cph) combinations with data 16'h8001: sck idle level equals ckp, and the sampling edge matches REQ-025/026. rsp_data equals the slave word in every mode.
REQ-039 req=11 held continuously: grants alternate 01, 10, 01, ... The first grant is requester 0, and the gap between successive gnt pulses is 34*DIV+1 cycles.
REQ-040 req=11 with requester 0 last served, then req drops to 01 before arbitration: requester 0 is granted. No grant occurs while req=00.
REQ-041 rst=0 asserted at T+20 mid-XFER: at the next edge ss_n=11, sck=0, busy=0, and no rsp_valid follows. The next req=11 grants requester 0.
REQ-042 DIV=1, back-to-back req=10: sck toggles every cycle, and rsp_valid appears at T+34 each time.
